// File: rtl/print_job_queue.sv
// print_job_queue: per-requester job buffer in front of the B/E/Y printer arbiter.
// Counts pending jobs, drives level requests rb/re/ry, times granted cycles
// against the arbiter's printer code and retires a job after JOB_LEN
// consecutive granted cycles. On retirement the request drops for one cycle
// (gap) so the arbiter can rotate.
// Optional build macro: PRINT_JOB_QUEUE_OVF_EN adds sticky drop flags (ovf)
// and their synchronous clear (ovf_clr).
// Channel index 0/1/2 = B/E/Y, matching grant codes 1/2/3.
module print_job_queue #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3,
  parameter int JOB_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_b,
  input  logic             push_e,
  input  logic             push_y,
  input  logic [1:0]       printer,
`ifdef PRINT_JOB_QUEUE_OVF_EN
  input  logic             ovf_clr,
  output logic [2:0]       ovf,
`endif
  output logic             rb,
  output logic             re,
  output logic             ry,
  output logic [CNT_W-1:0] pend_b,
  output logic [CNT_W-1:0] pend_e,
  output logic [CNT_W-1:0] pend_y,
  output logic [2:0]       full,
  output logic             job_done,
  output logic [1:0]       job_owner
);

  // JOB_LEN is at most 255, so an 8-bit timer never wraps before completion.
  localparam int TMR_W = 8;

  logic [2:0][CNT_W-1:0] pend_q, pend_d;
  logic [2:0]            gap_q, gap_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [1:0]            prev_code_q;
  logic                  job_done_q, job_done_d;
  logic [1:0]            job_owner_q, job_owner_d;

  logic [2:0]            push;
  logic [2:0]            done;
  logic [2:0]            drop;
  logic [CNT_W-1:0]      sel_pend;
  logic                  grant_ok;
  logic                  complete;
  logic [TMR_W-1:0]      eff_timer;

`ifdef PRINT_JOB_QUEUE_OVF_EN
  logic [2:0]            ovf_q, ovf_d;
`endif

  // Next-state: grant qualification, job timing, pend counters and gaps.
  always_comb begin
    push        = {push_y, push_e, push_b};
    done        = '0;
    drop        = '0;
    pend_d      = pend_q;
    gap_d       = '0;
    sel_pend    = '0;
    timer_d     = '0;
    job_done_d  = 1'b0;
    job_owner_d = job_owner_q;

    case (printer)
      2'd1:    sel_pend = pend_q[0];
      2'd2:    sel_pend = pend_q[1];
      2'd3:    sel_pend = pend_q[2];
      default: sel_pend = '0;
    endcase

    // A grant to an empty channel is spurious and does not count.
    grant_ok  = (printer != 2'd0) && (sel_pend != '0);
    // A changed grant code restarts the job: this cycle counts as the first.
    eff_timer = (printer == prev_code_q) ? timer_q : '0;
    complete  = grant_ok && (eff_timer == TMR_W'(JOB_LEN - 1));

    if (grant_ok && !complete) begin
      timer_d = eff_timer + 1'b1;
    end

    if (complete) begin
      job_done_d  = 1'b1;
      job_owner_d = printer;
    end

    for (int i = 0; i < 3; i++) begin
      done[i]   = complete && (printer == 2'(i + 1));
      // A completion in the same cycle frees a slot, so the push is taken.
      drop[i]   = push[i] && (pend_q[i] == CNT_W'(DEPTH)) && !done[i];
      pend_d[i] = pend_q[i] + CNT_W'(push[i] && !drop[i]) - CNT_W'(done[i]);
      gap_d[i]  = done[i];
    end
  end

`ifdef PRINT_JOB_QUEUE_OVF_EN
  // Sticky drop flags; a new drop outranks a simultaneous clear.
  always_comb begin
    ovf_d = (ovf_q & ~{3{ovf_clr}}) | drop;
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  // State registers; reset aborts any job in flight and discards the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      gap_q       <= '0;
      timer_q     <= '0;
      prev_code_q <= '0;
      job_done_q  <= 1'b0;
      job_owner_q <= '0;
    end else begin
      pend_q      <= pend_d;
      gap_q       <= gap_d;
      timer_q     <= timer_d;
      prev_code_q <= printer;
      job_done_q  <= job_done_d;
      job_owner_q <= job_owner_d;
    end
  end

  assign rb        = (pend_q[0] != '0) & ~gap_q[0];
  assign re        = (pend_q[1] != '0) & ~gap_q[1];
  assign ry        = (pend_q[2] != '0) & ~gap_q[2];
  assign pend_b    = pend_q[0];
  assign pend_e    = pend_q[1];
  assign pend_y    = pend_q[2];
  assign full      = {pend_q[2] == CNT_W'(DEPTH),
                      pend_q[1] == CNT_W'(DEPTH),
                      pend_q[0] == CNT_W'(DEPTH)};
  assign job_done  = job_done_q;
  assign job_owner = job_owner_q;

endmodule

// File: tb/tb_print_job_queue.sv
// Directed bench for print_job_queue with DEPTH=4, CNT_W=3, JOB_LEN=8.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_print_job_queue;

  logic       clk;
  logic       rst;
  logic       push_b, push_e, push_y;
  logic [1:0] printer;
  logic       rb, re, ry;
  logic [2:0] pend_b, pend_e, pend_y;
  logic [2:0] full;
  logic       job_done;
  logic [1:0] job_owner;
`ifdef PRINT_JOB_QUEUE_OVF_EN
  logic       ovf_clr;
  logic [2:0] ovf;
`endif

  int errors;
  int checks;

  print_job_queue #(.DEPTH(4), .CNT_W(3), .JOB_LEN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .push_b    (push_b),
    .push_e    (push_e),
    .push_y    (push_y),
    .printer   (printer),
`ifdef PRINT_JOB_QUEUE_OVF_EN
    .ovf_clr   (ovf_clr),
    .ovf       (ovf),
`endif
    .rb        (rb),
    .re        (re),
    .ry        (ry),
    .pend_b    (pend_b),
    .pend_e    (pend_e),
    .pend_y    (pend_y),
    .full      (full),
    .job_done  (job_done),
    .job_owner (job_owner)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reset pulse placed between edges.
  task automatic do_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick(1);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    push_b  = 1'b0;
    push_e  = 1'b0;
    push_y  = 1'b0;
    printer = 2'd0;
`ifdef PRINT_JOB_QUEUE_OVF_EN
    ovf_clr = 1'b0;
`endif
    tick(2);
    rst = 1'b0;

    // Reset state, then idle
    chk("rst_req",   {5'b0, rb, re, ry}, 8'h00);
    chk("rst_pend",  {2'b0, pend_b, pend_e}, 8'h00);
    chk("rst_full",  {5'b0, full}, 8'h00);
    chk("rst_done",  {5'b0, job_done, job_owner}, 8'h00);
    tick(5);
    chk("idle_req",  {5'b0, rb, re, ry}, 8'h00);
    chk("idle_pend", {5'b0, pend_y}, 8'h00);
    chk("idle_done", {5'b0, job_done, job_owner}, 8'h00);

    // Asynchronous reset mid-cycle
    push_b = 1'b1;
    tick(1);
    push_b = 1'b0;
    chk("push_pend_b", {5'b0, pend_b}, 8'h01);
    chk("push_rb",     {7'b0, rb}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("async_pend_b", {5'b0, pend_b}, 8'h00);
    chk("async_rb",     {7'b0, rb}, 8'h00);
    rst = 1'b0;
    tick(1);

    // Single job on B
    push_b = 1'b1;
    tick(1);
    push_b = 1'b0;
    printer = 2'd1;
    tick(7);
    chk("single_pre_done", {7'b0, job_done}, 8'h00);
    chk("single_pre_pend", {5'b0, pend_b}, 8'h01);
    tick(1);
    printer = 2'd0;
    chk("single_done",  {5'b0, job_done, job_owner}, 8'h05);
    chk("single_pend",  {5'b0, pend_b}, 8'h00);
    chk("single_rb",    {7'b0, rb}, 8'h00);
    tick(1);
    chk("single_after", {5'b0, job_done, job_owner}, 8'h01);
    chk("single_rb2",   {7'b0, rb}, 8'h00);

    // Full on E: fifth push dropped
    push_e = 1'b1;
    tick(5);
    push_e = 1'b0;
    chk("full_pend_e", {5'b0, pend_e}, 8'h04);
    chk("full_flags",  {5'b0, full}, 8'h02);
    chk("full_re",     {7'b0, re}, 8'h01);
`ifdef PRINT_JOB_QUEUE_OVF_EN
    chk("ovf_set", {5'b0, ovf}, 8'h02);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", {5'b0, ovf}, 8'h00);
`endif
    do_reset();
    chk("reset2_pend_e", {5'b0, pend_e}, 8'h00);

    // Same-cycle push and completion on B
    push_b = 1'b1;
    tick(2);
    push_b = 1'b0;
    chk("same_pend_b", {5'b0, pend_b}, 8'h02);
    printer = 2'd1;
    tick(7);
    push_b = 1'b1;
    tick(1);
    push_b = 1'b0;
    printer = 2'd0;
    chk("same_done",   {5'b0, job_done, job_owner}, 8'h05);
    chk("same_pend",   {5'b0, pend_b}, 8'h02);
    chk("same_gap_rb", {7'b0, rb}, 8'h00);
    tick(1);
    chk("same_rb_back", {7'b0, rb}, 8'h01);
    chk("same_done_lo", {7'b0, job_done}, 8'h00);

    // Completion while full still accepts the push
    push_b = 1'b1;
    tick(2);
    push_b = 1'b0;
    chk("full_b_pend", {5'b0, pend_b}, 8'h04);
    printer = 2'd1;
    tick(7);
    push_b = 1'b1;
    tick(1);
    push_b = 1'b0;
    printer = 2'd0;
    chk("fullpush_done", {7'b0, job_done}, 8'h01);
    chk("fullpush_pend", {5'b0, pend_b}, 8'h04);
    chk("fullpush_full", {5'b0, full}, 8'h01);
    do_reset();

    // Preemption of a Y job by a spurious B grant
    push_y = 1'b1;
    tick(1);
    push_y = 1'b0;
    printer = 2'd3;
    tick(5);
    printer = 2'd1;
    tick(2);
    chk("pre_done", {7'b0, job_done}, 8'h00);
    chk("pre_pend", {5'b0, pend_y}, 8'h01);
    chk("pre_ry",   {7'b0, ry}, 8'h01);
    printer = 2'd3;
    tick(7);
    chk("pre_7_done", {7'b0, job_done}, 8'h00);
    chk("pre_7_pend", {5'b0, pend_y}, 8'h01);
    tick(1);
    printer = 2'd0;
    chk("pre_done_y", {5'b0, job_done, job_owner}, 8'h07);
    chk("pre_pend_0", {5'b0, pend_y}, 8'h00);
    do_reset();

    // Rotation B, E, Y
    push_b = 1'b1;
    push_e = 1'b1;
    push_y = 1'b1;
    tick(1);
    push_b = 1'b0;
    push_e = 1'b0;
    push_y = 1'b0;
    chk("rot_req", {5'b0, rb, re, ry}, 8'h07);
    printer = 2'd1;
    tick(8);
    printer = 2'd2;
    chk("rot_b_done", {5'b0, job_done, job_owner}, 8'h05);
    chk("rot_b_req",  {5'b0, rb, re, ry}, 8'h03);
    tick(7);
    chk("rot_e_pre",  {7'b0, job_done}, 8'h00);
    tick(1);
    printer = 2'd3;
    chk("rot_e_done", {5'b0, job_done, job_owner}, 8'h06);
    chk("rot_e_req",  {5'b0, rb, re, ry}, 8'h01);
    tick(8);
    printer = 2'd0;
    chk("rot_y_done", {5'b0, job_done, job_owner}, 8'h07);
    chk("rot_y_req",  {5'b0, rb, re, ry}, 8'h00);
    tick(1);
    chk("rot_hold",   {5'b0, job_done, job_owner}, 8'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
